irq_sequencer: RTL and testbench
================================

Name: irq_sequencer

Overview:
- Sequences external-interrupt entry for the 5-stage pipelined CPU.
- Latches a timer/peripheral request and waits for a safe point at the ID stage (valid instruction, no load-use stall, no branch resolving in EX, user mode).
- At that point it pulses IRQ to the control unit, which redirects PCSrc to the ISR vector. In the same cycle it writes the return address to Xp ($26) and flushes IF/ID.
- It then tracks kernel-mode entry and exit so that interrupts never nest.

Parameters:
- ADDR_W, 32, PC width; bit ADDR_W-1 is the kernel-mode flag.
- CNT_W, 8, width of the saturating serviced-interrupt counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- irq_req  in  1  interrupt request from timer/peripheral.
- id_pcplus  in  ADDR_W  PC+4 of the instruction in ID (IF/ID PCplusout).
- id_valid  in  1  ID holds a real instruction, not a bubble.
- datahazard  in  1  load-use stall active this cycle.
- ex_branch  in  1  branch/jump in EX redirects the PC this cycle.
- IRQ  out  1  interrupt strobe to the control unit.
- flush_ifid  out  1  squash the instruction entering IF/ID.
- xp_wr  out  1  write enable for register $26.
- xp_data  out  ADDR_W  return address (PC+4 of the interrupted instruction).
- irq_clr  out  1  acknowledge pulse back to the requester.
- busy  out  1  state is not IDLE.
- irq_count  out  CNT_W  number of serviced interrupts, saturating.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, pend=0, irq_count=0.
  - All single-cycle outputs are 0; xp_data=0.
  - A reset mid-sequence abandons it with no IRQ pulse.
- pend flag:
  - Set in any cycle with irq_req==1 (level-sensitive by default).
  - Cleared in the inject cycle.
  - Set and clear in the same cycle: set wins, so the request is re-queued.
- Kernel test: kern = id_pcplus[ADDR_W-1].
- Safe point: safe = id_valid & ~datahazard & ~ex_branch & ~kern.
- States are IDLE, PEND, WAIT_K and KERNEL, encoded 2-bit.
  - IDLE: pend==1 -> PEND.
  - PEND: safe==1 is the inject cycle.
    - Outputs IRQ=1, xp_wr=1, flush_ifid=1, irq_clr=1 and xp_data=id_pcplus, all combinational (Mealy) in that same cycle.
    - irq_count increments, saturating at all-ones.
    - Next state is WAIT_K.
    - Otherwise stay in PEND with outputs 0.
  - WAIT_K: waits for the ISR fetch to reach ID.
    - id_valid & kern -> KERNEL.
    - A non-kernel valid instruction may appear in ID while waiting; it must not re-trigger and stays in WAIT_K.
  - KERNEL: id_valid & ~kern (ISR returned via jr $26) -> IDLE.
    - pend remains set if a new request arrived during the ISR, so the next cycle goes to PEND.
- Outside the inject cycle: IRQ, xp_wr, flush_ifid and irq_clr are 0, and xp_data holds its last value (registered copy).
- Priority in PEND: ex_branch blocks injection, because the branch target wins and the interrupt is taken at the target instruction. datahazard also blocks injection.
- Latency from an idle pipeline: irq_req at cycle N -> pend at N+1 -> PEND at N+2 -> earliest IRQ in cycle N+2.
- busy = (state != IDLE).

Optional Feature:
- IRQ_EDGE_EN defined:
  - pend sets only on a rising edge of irq_req, detected with a registered previous sample that resets to 0.
  - A level held high across an ISR is serviced exactly once.
- IRQ_EDGE_EN undefined: level-sensitive as above. The requester must drop irq_req on irq_clr, otherwise the request is re-serviced after KERNEL exit.

Test Plan:
- Reset: hold reset=0 for 3 cycles with irq_req=1 -> IRQ=0, busy=0, irq_count=0. First IRQ occurs 2 cycles after reset=1.
- Basic entry: id_pcplus=0x0000_0040, id_valid=1, pulse irq_req -> in one cycle IRQ=xp_wr=flush_ifid=irq_clr=1 with xp_data=0x0000_0040; irq_count=1.
- Blocked by hazards: pend set with datahazard=1 for 2 cycles, then ex_branch=1 for 1 cycle -> IRQ stays 0. IRQ asserts on the first cycle where both are 0.
- No nesting: after inject, drive id_pcplus=0x8000_0008 (kern), pulse irq_req -> no IRQ. Then id_pcplus=0x0000_0044 valid -> IDLE, then PEND, then IRQ; irq_count=2.
- Kernel at request: irq_req while id_pcplus=0x8000_0010 -> waits in PEND, and IRQ only fires once id_pcplus bit31=0.
- Edge mode (IRQ_EDGE_EN): hold irq_req=1 across a full ISR -> exactly one IRQ and irq_count=1. Without the macro -> a second IRQ after KERNEL exit.

Source files
------------

// File: rtl/irq_sequencer.sv
// irq_sequencer: interrupt-entry sequencer for the 5-stage pipeline; define IRQ_EDGE_EN for edge-triggered requests
module irq_sequencer #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              irq_req,
    input  logic [ADDR_W-1:0] id_pcplus,
    input  logic              id_valid,
    input  logic              datahazard,
    input  logic              ex_branch,
    output logic              IRQ,
    output logic              flush_ifid,
    output logic              xp_wr,
    output logic [ADDR_W-1:0] xp_data,
    output logic              irq_clr,
    output logic              busy,
    output logic [CNT_W-1:0]  irq_count
);
    typedef enum logic [1:0] {IDLE, PEND, WAIT_K, KERNEL} state_t;
    state_t            state;
    logic              pend;
    logic              set_req;
    logic              kern;
    logic              safe;
    logic              inject;
    logic [ADDR_W-1:0] xp_q;
`ifdef IRQ_EDGE_EN
    logic req_q;
    // previous request sample so a held level is queued only once
    always_ff @(posedge clk) req_q <= reset ? irq_req : 1'b0;
    assign set_req = irq_req & ~req_q;
`else
    assign set_req = irq_req;
`endif
    assign kern       = id_pcplus[ADDR_W-1];
    assign safe       = id_valid & ~datahazard & ~ex_branch & ~kern;
    assign inject     = reset & (state == PEND) & safe;
    assign IRQ        = inject;
    assign xp_wr      = inject;
    assign flush_ifid = inject;
    assign irq_clr    = inject;
    assign xp_data    = inject ? id_pcplus : xp_q;
    assign busy       = state != IDLE;
    // sequencer state, pending request, held return address and serviced count
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            pend      <= 1'b0;
            xp_q      <= '0;
            irq_count <= '0;
        end else begin
            pend <= set_req | (pend & ~inject);
            if (inject) begin
                xp_q <= id_pcplus;
                if (irq_count != '1) irq_count <= irq_count + CNT_W'(1);
            end
            case (state)
                IDLE:    if (pend) state <= PEND;
                PEND:    if (inject) state <= WAIT_K;
                WAIT_K:  if (id_valid & kern) state <= KERNEL;
                KERNEL:  if (id_valid & ~kern) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_irq_sequencer.sv
// tb_irq_sequencer: randomized and directed checks of irq_sequencer against a rule-level model
module tb_irq_sequencer;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;
    logic              clk = 1'b0;
    logic              reset, irq_req, id_valid, datahazard, ex_branch;
    logic [ADDR_W-1:0] id_pcplus;
    logic              IRQ, flush_ifid, xp_wr, irq_clr, busy;
    logic [ADDR_W-1:0] xp_data;
    logic [CNT_W-1:0]  irq_count;
    int n_chk = 0, n_fail = 0, n_irq = 0;
    bit m_pending, m_armed, m_in_isr, m_entered, m_prev;
    int m_cnt;
    logic [ADDR_W-1:0] m_xp;

    irq_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .irq_req(irq_req), .id_pcplus(id_pcplus),
        .id_valid(id_valid), .datahazard(datahazard), .ex_branch(ex_branch),
        .IRQ(IRQ), .flush_ifid(flush_ifid), .xp_wr(xp_wr), .xp_data(xp_data),
        .irq_clr(irq_clr), .busy(busy), .irq_count(irq_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pending = 0; m_armed = 0; m_in_isr = 0; m_entered = 0; m_prev = 0;
        m_cnt = 0; m_xp = '0;
    endtask

    // one clock: drive inputs, check outputs mid-cycle, then advance the model
    task automatic cyc(input bit rs, input bit rq, input logic [31:0] pc, input bit v, input bit dh, input bit br);
        bit kern, safe, inj, set;
        reset = rs; irq_req = rq; id_pcplus = pc; id_valid = v; datahazard = dh; ex_branch = br;
        @(negedge clk);
        kern = pc[31];
        safe = v && !dh && !br && !kern;
        inj  = rs && m_armed && safe;
        if (IRQ === 1'b1) n_irq++;
        chk("irq", IRQ, inj);
        chk("xp_wr", xp_wr, inj);
        chk("flush", flush_ifid, inj);
        chk("irq_clr", irq_clr, inj);
        chk("xp_data", xp_data, inj ? pc : m_xp);
        chk("busy", busy, m_armed || m_in_isr);
        chk("count", irq_count, m_cnt);
        if (!rs) model_reset();
        else begin
`ifdef IRQ_EDGE_EN
            set = rq && !m_prev;
`else
            set = rq;
`endif
            m_prev = rq;
            if (inj) begin
                m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
                m_xp = pc;
                m_armed = 0; m_in_isr = 1; m_entered = 0;
            end else if (m_in_isr) begin
                if (!m_entered && v && kern) m_entered = 1;
                else if (m_entered && v && !kern) m_in_isr = 0;
            end else if (!m_armed) m_armed = m_pending;
            m_pending = set || (m_pending && !inj);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int seen;
        reset = 0; irq_req = 0; id_pcplus = '0; id_valid = 0; datahazard = 0; ex_branch = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        // reset held with a request present, then first IRQ two cycles after release
        repeat (3) cyc(0, 1, 32'h40, 1, 0, 0);
        cyc(1, 1, 32'h40, 1, 0, 0);
        cyc(1, 0, 32'h40, 1, 0, 0);
        cyc(1, 0, 32'h40, 1, 0, 0);
        chk("first_irq_xp", xp_data, 32'h40);
        cyc(1, 0, 32'h8000_0008, 1, 0, 0);
        cyc(1, 0, 32'h44, 1, 0, 0);
        // basic entry
        cyc(0, 0, 32'h40, 1, 0, 0);
        cyc(1, 1, 32'h40, 1, 0, 0);
        repeat (3) cyc(1, 0, 32'h40, 1, 0, 0);
        chk("basic_count", irq_count, 1);
        // no nesting: request while in kernel, then return to user
        cyc(1, 1, 32'h8000_0008, 1, 0, 0);
        repeat (2) cyc(1, 0, 32'h8000_0008, 1, 0, 0);
        repeat (4) cyc(1, 0, 32'h44, 1, 0, 0);
        chk("nest_count", irq_count, 2);
        cyc(1, 0, 32'h8000_0000, 1, 0, 0);
        cyc(1, 0, 32'h48, 1, 0, 0);
        // hazards block injection
        cyc(1, 1, 32'h50, 1, 0, 0);
        cyc(1, 0, 32'h50, 1, 0, 0);
        repeat (2) cyc(1, 0, 32'h50, 1, 1, 0);
        cyc(1, 0, 32'h50, 1, 0, 1);
        cyc(1, 0, 32'h54, 1, 0, 0);
        chk("hazard_xp", xp_data, 32'h54);
        cyc(1, 0, 32'h8000_0000, 1, 0, 0);
        cyc(1, 0, 32'h58, 1, 0, 0);
        // request while ID holds a kernel PC
        cyc(1, 1, 32'h8000_0010, 1, 0, 0);
        repeat (4) cyc(1, 0, 32'h8000_0010, 1, 0, 0);
        cyc(1, 0, 32'h200, 1, 0, 0);
        cyc(1, 0, 32'h8000_0000, 1, 0, 0);
        cyc(1, 0, 32'h204, 1, 0, 0);
        // level held across a whole ISR
        cyc(0, 0, 32'h100, 1, 0, 0);
        seen = n_irq;
        repeat (3) cyc(1, 1, 32'h100, 1, 0, 0);
        repeat (3) cyc(1, 1, 32'h8000_0000, 1, 0, 0);
        cyc(1, 1, 32'h104, 1, 0, 0);
        repeat (4) cyc(1, 0, 32'h108, 1, 0, 0);
`ifdef IRQ_EDGE_EN
        chk("held_irqs", n_irq - seen, 1);
`else
        chk("held_irqs", n_irq - seen, 2);
`endif
        cyc(1, 0, 32'h8000_0000, 1, 0, 0);
        cyc(1, 0, 32'h10c, 1, 0, 0);
        // randomized traffic, including occasional mid-sequence reset and counter saturation
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 199) != 0, $urandom_range(0, 5) == 0,
                {$urandom_range(0, 1) == 1, 31'($urandom)}, $urandom_range(0, 3) != 0,
                $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
